// File: rtl/ceres_lowx_arbiter.sv
// ---------------------------------------------------------------------------
// ceres_lowx_arbiter
//
// Purpose:
//   Shares the single lower-level (lowX) memory port between the icache miss
//   path and the dcache miss/writeback path. One block transaction is in
//   flight at a time. Simultaneous requests are resolved round-robin: the
//   cache that did not win the previous grant wins the next tie.
//
//   Transaction flow:  IDLE -> REQ -> RSP -> DLV -> IDLE
//     IDLE : accept one request (combinational ready), latch its fields
//     REQ  : present latched request to memory until mem_req_ready_i
//     RSP  : accept one memory response, latch the block
//     DLV  : present the block to the owning cache until it consumes it
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A sender holds valid and its payload
//   stable until that edge; ready may depend combinationally on valid.
//
// Ports:
//   clk_i, rst_i                 clock / asynchronous active-high reset
//   ic_req_*                     icache request channel (read only)
//   ic_res_*                     icache response channel
//   dc_req_*                     dcache request channel (read or write)
//   dc_res_*                     dcache response channel
//   mem_req_*                    request channel towards memory adapter
//   mem_res_*                    response channel from memory adapter
//   busy_o                       a transaction is in progress
// ---------------------------------------------------------------------------
module ceres_lowx_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ic_req_valid_i,
    output logic                ic_req_ready_o,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_req_uncached_i,
    output logic                ic_res_valid_o,
    input  logic                ic_res_ready_i,
    output logic [BLK_SIZE-1:0] ic_res_blk_o,

    input  logic                dc_req_valid_i,
    output logic                dc_req_ready_o,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_uncached_i,
    input  logic                dc_req_rw_i,
    input  logic [BLK_SIZE-1:0] dc_req_wdata_i,
    output logic                dc_res_valid_o,
    input  logic                dc_res_ready_i,
    output logic [BLK_SIZE-1:0] dc_res_blk_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_uncached_o,
    output logic                mem_req_rw_o,
    output logic [BLK_SIZE-1:0] mem_req_wdata_o,
    input  logic                mem_res_valid_i,
    output logic                mem_res_ready_o,
    input  logic [BLK_SIZE-1:0] mem_res_blk_i,

    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DLV  = 2'd3
    } state_e;

    // Requester identity, used both for the transaction owner and for the
    // round-robin "last winner" record.
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_e                state_q,    state_d;
    logic                  owner_q,    owner_d;
    logic                  rr_last_q,  rr_last_d;
    logic [XLEN-1:0]       addr_q,     addr_d;
    logic                  uncached_q, uncached_d;
    logic                  rw_q,       rw_d;
    logic [BLK_SIZE-1:0]   wdata_q,    wdata_d;
    logic [BLK_SIZE-1:0]   blk_q,      blk_d;

    logic                  is_idle;
    logic                  ic_win;
    logic                  dc_win;
    logic                  owner_res_ready;

    // ------------------------------------------------------------------
    // Arbitration. A lone requester always wins; on a tie the requester
    // that did not win last time goes first. The two win terms are
    // mutually exclusive by construction, so at most one ready is high.
    // ------------------------------------------------------------------
    always_comb begin
        is_idle = (state_q == S_IDLE);
        ic_win  = ic_req_valid_i & (~dc_req_valid_i | (rr_last_q == OWN_DC));
        dc_win  = dc_req_valid_i & (~ic_req_valid_i | (rr_last_q == OWN_IC));
        owner_res_ready = (owner_q == OWN_DC) ? dc_res_ready_i : ic_res_ready_i;
    end

    // ------------------------------------------------------------------
    // Next-state and datapath capture.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        addr_d     = addr_q;
        uncached_d = uncached_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        blk_d      = blk_q;

        unique case (state_q)
            S_IDLE: begin
                if (ic_win) begin
                    // Instruction fetches are always reads with no payload.
                    owner_d    = OWN_IC;
                    rr_last_d  = OWN_IC;
                    addr_d     = ic_req_addr_i;
                    uncached_d = ic_req_uncached_i;
                    rw_d       = 1'b0;
                    wdata_d    = '0;
                    state_d    = S_REQ;
                end else if (dc_win) begin
                    owner_d    = OWN_DC;
                    rr_last_d  = OWN_DC;
                    addr_d     = dc_req_addr_i;
                    uncached_d = dc_req_uncached_i;
                    rw_d       = dc_req_rw_i;
                    wdata_d    = dc_req_wdata_i;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_RSP;
                end
            end

            S_RSP: begin
                // A write acknowledge is handled exactly like read data;
                // the dcache simply ignores the block it gets back.
                if (mem_res_valid_i) begin
                    blk_d   = mem_res_blk_i;
                    state_d = S_DLV;
                end
            end

            S_DLV: begin
                if (owner_res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset makes the icache win the first tie by
    // recording the dcache as the last winner.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IC;
            rr_last_q  <= OWN_DC;
            addr_q     <= '0;
            uncached_q <= 1'b0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            blk_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            addr_q     <= addr_d;
            uncached_q <= uncached_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            blk_q      <= blk_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Everything except the two request readies is a pure decode
    // of registered state, so async reset clears them in the same cycle.
    // ------------------------------------------------------------------
    assign ic_req_ready_o     = is_idle & ic_win;
    assign dc_req_ready_o     = is_idle & dc_win;

    assign mem_req_valid_o    = (state_q == S_REQ);
    assign mem_req_addr_o     = addr_q;
    assign mem_req_uncached_o = uncached_q;
    assign mem_req_rw_o       = rw_q;
    assign mem_req_wdata_o    = wdata_q;

    assign mem_res_ready_o    = (state_q == S_RSP);

    assign ic_res_valid_o     = (state_q == S_DLV) & (owner_q == OWN_IC);
    assign dc_res_valid_o     = (state_q == S_DLV) & (owner_q == OWN_DC);
    assign ic_res_blk_o       = blk_q;
    assign dc_res_blk_o       = blk_q;

    assign busy_o             = ~is_idle;

endmodule

// File: tb/tb_ceres_lowx_arbiter.sv
module tb_ceres_lowx_arbiter;
    localparam int XLEN = 32;
    localparam int BLK  = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic             ic_req_valid_i, ic_req_ready_o, ic_req_uncached_i;
    logic [XLEN-1:0]  ic_req_addr_i;
    logic             ic_res_valid_o, ic_res_ready_i;
    logic [BLK-1:0]   ic_res_blk_o;
    logic             dc_req_valid_i, dc_req_ready_o, dc_req_uncached_i, dc_req_rw_i;
    logic [XLEN-1:0]  dc_req_addr_i;
    logic [BLK-1:0]   dc_req_wdata_i;
    logic             dc_res_valid_o, dc_res_ready_i;
    logic [BLK-1:0]   dc_res_blk_o;
    logic             mem_req_valid_o, mem_req_ready_i, mem_req_uncached_o, mem_req_rw_o;
    logic [XLEN-1:0]  mem_req_addr_o;
    logic [BLK-1:0]   mem_req_wdata_o;
    logic             mem_res_valid_i, mem_res_ready_o;
    logic [BLK-1:0]   mem_res_blk_i;
    logic             busy_o;

    ceres_lowx_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_req_addr_i(ic_req_addr_i), .ic_req_uncached_i(ic_req_uncached_i),
        .ic_res_valid_o(ic_res_valid_o), .ic_res_ready_i(ic_res_ready_i),
        .ic_res_blk_o(ic_res_blk_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_uncached_i(dc_req_uncached_i),
        .dc_req_rw_i(dc_req_rw_i), .dc_req_wdata_i(dc_req_wdata_i),
        .dc_res_valid_o(dc_res_valid_o), .dc_res_ready_i(dc_res_ready_i),
        .dc_res_blk_o(dc_res_blk_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_uncached_o(mem_req_uncached_o),
        .mem_req_rw_o(mem_req_rw_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_res_valid_i(mem_res_valid_i), .mem_res_ready_o(mem_res_ready_o),
        .mem_res_blk_i(mem_res_blk_i),
        .busy_o(busy_o)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction: open -> sent to memory -> response held
    // -> delivered. Grants are logged (0 = icache, 1 = dcache).
    bit              m_open, m_sent, m_held, m_owner, m_last;
    logic [XLEN-1:0] m_addr;
    logic            m_unc, m_rw;
    logic [BLK-1:0]  m_wdata, m_blk;
    bit              grant_log[$];

    task automatic model_reset();
        m_open = 0; m_sent = 0; m_held = 0; m_owner = 0;
        m_last = 1;             // dcache counted as last winner
        m_addr = '0; m_unc = 0; m_rw = 0; m_wdata = '0; m_blk = '0;
    endtask

    // One clock cycle: compare every output against the model, advance the
    // model by the transfers that happen on the coming edge, then step.
    task automatic tick();
        bit e_ic, e_dc, tie_ic;
        #1;
        tie_ic = (m_last == 1);
        e_ic = !m_open && ic_req_valid_i && (!dc_req_valid_i || tie_ic);
        e_dc = !m_open && dc_req_valid_i && (!ic_req_valid_i || !tie_ic);
        chk("ic_req_ready", ic_req_ready_o, e_ic);
        chk("dc_req_ready", dc_req_ready_o, e_dc);
        chk("both_ready", ic_req_ready_o & dc_req_ready_o, 0);
        chk("mem_req_valid", mem_req_valid_o, m_open && !m_sent);
        chk("mem_res_ready", mem_res_ready_o, m_open && m_sent && !m_held);
        chk("ic_res_valid", ic_res_valid_o, m_held && !m_owner);
        chk("dc_res_valid", dc_res_valid_o, m_held && m_owner);
        chk("busy", busy_o, m_open);
        chk("mem_req_addr", mem_req_addr_o, m_addr);
        chk("mem_req_unc", mem_req_uncached_o, m_unc);
        chk("mem_req_rw", mem_req_rw_o, m_rw);
        chk("mem_req_wdata", mem_req_wdata_o, m_wdata);
        chk("ic_res_blk", ic_res_blk_o, m_blk);
        chk("dc_res_blk", dc_res_blk_o, m_blk);

        if (!m_open) begin
            if (e_ic) begin
                m_open = 1; m_owner = 0; m_last = 0;
                m_addr = ic_req_addr_i; m_unc = ic_req_uncached_i;
                m_rw = 0; m_wdata = '0;
                grant_log.push_back(0);
            end else if (e_dc) begin
                m_open = 1; m_owner = 1; m_last = 1;
                m_addr = dc_req_addr_i; m_unc = dc_req_uncached_i;
                m_rw = dc_req_rw_i; m_wdata = dc_req_wdata_i;
                grant_log.push_back(1);
            end
        end else if (!m_sent) begin
            if (mem_req_ready_i) m_sent = 1;
        end else if (!m_held) begin
            if (mem_res_valid_i) begin
                m_held = 1; m_blk = mem_res_blk_i;
            end
        end else if (m_owner ? dc_res_ready_i : ic_res_ready_i) begin
            m_open = 0; m_sent = 0; m_held = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ic_req_valid_i = 0; ic_req_addr_i = '0; ic_req_uncached_i = 0; ic_res_ready_i = 0;
        dc_req_valid_i = 0; dc_req_addr_i = '0; dc_req_uncached_i = 0; dc_req_rw_i = 0;
        dc_req_wdata_i = '0; dc_res_ready_i = 0;
        mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 0;
    endtask

    localparam logic [BLK-1:0] A5_BLK = {16{8'hA5}};
    localparam logic [BLK-1:0] W_BLK  = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    localparam logic [BLK-1:0] B_BLK  = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [BLK-1:0] C_BLK  = 128'hc0de_c0de_c0de_c0de_0123_4567_89ab_cdef;

    initial begin
        rst_i = 0;
        do_reset();

        // ---- reset state ----
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_res_valid", {ic_res_valid_o, dc_res_valid_o, mem_res_ready_o}, 0);
        chk("rst_addr", mem_req_addr_o, 0);
        chk("rst_blk", ic_res_blk_o, 0);

        // ---- single icache read, zero-wait memory ----
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_0040;
        mem_req_ready_i = 1; mem_res_valid_i = 1; mem_res_blk_i = A5_BLK;
        ic_res_ready_i = 1;
        #1 chk("rd_accept_T", ic_req_ready_o, 1);
        tick();                                   // T
        chk("rd_memvalid_T1", mem_req_valid_o, 1);
        chk("rd_addr_T1", mem_req_addr_o, 32'h8000_0040);
        chk("rd_rw_T1", mem_req_rw_o, 0);
        ic_req_valid_i = 0;
        tick();                                   // T+1
        chk("rd_resready_T2", mem_res_ready_o, 1);
        chk("rd_noresp_T2", ic_res_valid_o, 0);
        tick();                                   // T+2
        chk("rd_resvalid_T3", ic_res_valid_o, 1);
        chk("rd_blk_T3", ic_res_blk_o, A5_BLK);
        chk("rd_dc_quiet_T3", dc_res_valid_o, 0);
        tick();                                   // T+3
        chk("rd_idle_T4", busy_o, 0);

        // ---- round-robin with both requesting every cycle ----
        do_reset();
        grant_log.delete();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_1000;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h8000_2000; dc_req_rw_i = 0;
        mem_req_ready_i = 1; mem_res_valid_i = 1; mem_res_blk_i = B_BLK;
        ic_res_ready_i = 1; dc_res_ready_i = 1;
        for (int i = 0; i < 16; i++) tick();
        ic_req_valid_i = 0; dc_req_valid_i = 0;
        chk("rr_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("rr_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
        end
        tick();

        // ---- dcache write with memory stall, then response backpressure ----
        dc_req_valid_i = 1; dc_req_addr_i = 32'h8000_0100; dc_req_rw_i = 1;
        dc_req_wdata_i = W_BLK; dc_req_uncached_i = 1;
        mem_req_ready_i = 0; mem_res_valid_i = 0;
        ic_res_ready_i = 0; dc_res_ready_i = 1;
        tick();
        dc_req_valid_i = 0; dc_req_wdata_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_hold_valid", mem_req_valid_o, 1);
            chk("wr_hold_rw", mem_req_rw_o, 1);
            chk("wr_hold_wdata", mem_req_wdata_o, W_BLK);
            chk("wr_hold_addr", mem_req_addr_o, 32'h8000_0100);
            tick();
        end
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0; mem_res_valid_i = 1; mem_res_blk_i = B_BLK;
        tick();
        mem_res_valid_i = 0; mem_res_blk_i = '0;
        chk("wr_ack_valid", dc_res_valid_o, 1);
        dc_res_ready_i = 0;
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_3000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_dc_valid", dc_res_valid_o, 1);
            chk("bp_dc_blk", dc_res_blk_o, B_BLK);
            chk("bp_ic_blocked", ic_req_ready_o, 0);
            tick();
        end
        dc_res_ready_i = 1;
        tick();
        #1 chk("bp_ic_after", ic_req_ready_o, 1);
        tick();
        ic_req_valid_i = 0;
        mem_req_ready_i = 1; mem_res_valid_i = 1; mem_res_blk_i = A5_BLK; ic_res_ready_i = 1;
        for (int i = 0; i < 3; i++) tick();

        // ---- spurious memory responses in IDLE and REQ ----
        idle_inputs();
        mem_res_valid_i = 1; mem_res_blk_i = B_BLK;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("spur_idle_ready", mem_res_ready_o, 0);
            chk("spur_idle_resp", {ic_res_valid_o, dc_res_valid_o}, 0);
            tick();
        end
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_4000;
        tick();
        ic_req_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("spur_req_ready", mem_res_ready_o, 0);
            chk("spur_req_resp", ic_res_valid_o, 0);
            tick();
        end
        mem_req_ready_i = 1; mem_res_valid_i = 0;
        tick();
        mem_req_ready_i = 0; mem_res_valid_i = 1; mem_res_blk_i = C_BLK;
        tick();
        mem_res_valid_i = 0;
        chk("spur_blk_real", ic_res_blk_o, C_BLK);
        ic_res_ready_i = 1;
        tick();

        // ---- asynchronous reset while in REQ ----
        idle_inputs();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h8000_5000;
        tick();
        ic_req_valid_i = 0;
        tick();
        chk("arst_pre_req", mem_req_valid_o, 1);
        #2 rst_i = 1;
        #1;
        chk("arst_mem_valid", mem_req_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_others", {mem_res_ready_o, ic_res_valid_o, dc_res_valid_o}, 0);
        model_reset();
        @(posedge clk);
        #1 rst_i = 0;
        ic_req_valid_i = 1; dc_req_valid_i = 1;
        #1;
        chk("arst_tie_ic", ic_req_ready_o, 1);
        chk("arst_tie_dc", dc_req_ready_o, 0);
        tick();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            ic_req_valid_i    = ($urandom_range(0, 2) != 0);
            ic_req_addr_i     = $urandom;
            ic_req_uncached_i = $urandom_range(0, 1);
            ic_res_ready_i    = $urandom_range(0, 1);
            dc_req_valid_i    = ($urandom_range(0, 2) != 0);
            dc_req_addr_i     = $urandom;
            dc_req_uncached_i = $urandom_range(0, 1);
            dc_req_rw_i       = $urandom_range(0, 1);
            dc_req_wdata_i    = {$urandom, $urandom, $urandom, $urandom};
            dc_res_ready_i    = $urandom_range(0, 1);
            mem_req_ready_i   = ($urandom_range(0, 3) != 0);
            mem_res_valid_i   = $urandom_range(0, 1);
            mem_res_blk_i     = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
